// File: rtl/dpram_fifo_pkg.sv
// rtl/dpram_fifo_pkg.sv - shared output-buffer state encoding for the dual-port RAM FIFO
package dpram_fifo_pkg;

    typedef enum logic [1:0] {
        OBUF_EMPTY = 2'd0,
        OBUF_ONE   = 2'd1,
        OBUF_TWO   = 2'd2
    } obuf_state_t;

    function automatic logic [1:0] obuf_fill(input obuf_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            OBUF_ONE: n = 2'd1;
            OBUF_TWO: n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dpram_fifo_obuf.sv
// rtl/dpram_fifo_obuf.sv - 2-entry show-ahead skid buffer fed by the RAM read port
module dpram_fifo_obuf
    import dpram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  valid,
    output logic [1:0]            fill
);

    obuf_state_t           state, state_next;
    logic [DATA_WIDTH-1:0] second;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= OBUF_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OBUF_EMPTY: if (load) state_next = OBUF_ONE;
            OBUF_ONE: begin
                if (load && !pop)      state_next = OBUF_TWO;
                else if (pop && !load) state_next = OBUF_EMPTY;
            end
            OBUF_TWO:   if (pop && !load) state_next = OBUF_ONE;
            default:    state_next = OBUF_EMPTY;
        endcase
    end

    // The read issue logic never loads a full buffer unless the head is popped too.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            second    <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= (state_next != OBUF_EMPTY);
            case (state)
                OBUF_EMPTY: if (load) head_data <= load_data;
                OBUF_ONE: begin
                    if (load && pop) head_data <= load_data;
                    else if (load)   second    <= load_data;
                end
                OBUF_TWO: begin
                    if (pop) begin
                        head_data <= second;
                        if (load) second <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill = obuf_fill(state);

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller around an external 1-cycle-read simple dual-port RAM
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic [DATA_WIDTH-1:0] ram_wrdata,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         ram_cnt, count_q, count_next;
    logic                  inflight, full_q;
    logic                  push_ok, pop_ok, issue;
    logic [1:0]            obuf_cnt;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && valid;

    // Only words already in RAM (registered ram_cnt) are readable, so a same-cycle write is never read.
    assign issue = (ram_cnt != '0) &&
                   (({1'b0, obuf_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop_ok}));

    assign ram_wren      = push_ok && rst_n;
    assign ram_wraddress = wr_ptr;
    assign ram_wrdata    = push_data;
    assign ram_rdaddress = rd_ptr;

    assign count_next = count_q + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            inflight  <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (issue)   rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt + CW'(push_ok) - CW'(issue);
            inflight <= issue;
            count_q  <= count_next;
            full_q   <= (count_next == CW'(DEPTH));
            if (push && full_q) overflow  <= 1'b1;
            if (pop && !valid)  underflow <= 1'b1;
        end
    end

    dpram_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (inflight),
        .load_data (ram_rddata),
        .pop       (pop_ok),
        .head_data (pop_data),
        .valid     (valid),
        .fill      (obuf_cnt)
    );

    assign count = count_q;
    assign full  = full_q;

endmodule
